lc3_decode_stage: RTL and testbench



---
 rtl/lc3_decode_pkg.sv | 49 ++++
 rtl/lc3_decode_ctrl_lut.sv | 78 +++++++
 rtl/lc3_decode_stage.sv | 85 ++++++++
 tb/tb_lc3_decode_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_decode_pkg.sv
// lc3_decode_pkg
//   Shared types and constants for the LC3 Decode stage.
//   - opcode_t      : 4-bit LC3 opcode field (IR[15:12])
//   - W_ALU/W_MEM/W_PC : writeback source select encodings
//   - PCSEL1_*      : pcselect1 encodings (offset9, offset6, zero)
//   - ALU_*         : alu_control encodings
//   - e_ctrl_t      : Execute control word, packed MSB-first as
//                     {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  localparam logic [1:0] W_ALU = 2'd0;
  localparam logic [1:0] W_MEM = 2'd1;
  localparam logic [1:0] W_PC  = 2'd2;

  localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_ctrl_t;

endpackage

// File: rtl/lc3_decode_ctrl_lut.sv
// lc3_decode_ctrl_lut
//   Purely combinational instruction -> control lookup for the Decode stage.
//   Ports:
//     instr        in  16  instruction word (only [15:12] and [5] matter)
//     e_control    out 6   Execute control word (e_ctrl_t)
//     w_control    out 2   writeback source select
//     mem_control  out 1   1 = indirect memory access (LDI/STI)
//     illegal      out 1   1 = opcode not supported by this pipeline
//   Unsupported opcodes (JSR, RTI, 1101, TRAP) produce all-zero controls.
module lc3_decode_ctrl_lut
  import lc3_decode_pkg::*;
(
  input  logic [15:0] instr,
  output e_ctrl_t     e_control,
  output logic [1:0]  w_control,
  output logic        mem_control,
  output logic        illegal
);

  opcode_t opcode;
  assign opcode = opcode_t'(instr[15:12]);

  // Operand fields are decoded downstream from IR; they do not affect controls.
  logic unused_fields;
  assign unused_fields = ^{instr[11:6], instr[4:0]};

  always_comb begin
    e_control   = '0;
    w_control   = W_ALU;
    mem_control = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_ADD: begin
        e_control.alu_control = ALU_ADD;
        // instr[5]=1 is immediate mode, so register operand is selected when 0
        e_control.op2select   = ~instr[5];
      end
      OP_AND: begin
        e_control.alu_control = ALU_AND;
        e_control.op2select   = ~instr[5];
      end
      OP_NOT: e_control.alu_control = ALU_NOT;
      OP_BR, OP_ST: begin
        e_control.pcselect1 = PCSEL1_OFF9;
        e_control.pcselect2 = 1'b1;
      end
      OP_LD: begin
        e_control.pcselect1 = PCSEL1_OFF9;
        e_control.pcselect2 = 1'b1;
        w_control           = W_MEM;
      end
      OP_LDI: begin
        e_control.pcselect1 = PCSEL1_OFF9;
        e_control.pcselect2 = 1'b1;
        w_control           = W_MEM;
        mem_control         = 1'b1;
      end
      OP_STI: begin
        e_control.pcselect1 = PCSEL1_OFF9;
        e_control.pcselect2 = 1'b1;
        mem_control         = 1'b1;
      end
      OP_LEA: begin
        e_control.pcselect1 = PCSEL1_OFF9;
        e_control.pcselect2 = 1'b1;
        w_control           = W_PC;
      end
      OP_LDR: begin
        e_control.pcselect1 = PCSEL1_OFF6;
        w_control           = W_MEM;
      end
      OP_STR: e_control.pcselect1 = PCSEL1_OFF6;
      OP_JMP: e_control.pcselect1 = PCSEL1_ZERO;
      default: illegal = 1'b1;  // JSR, RTI, reserved, TRAP
    endcase
  end

endmodule

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage
//   LC3 Decode pipeline stage: captures the fetched instruction and its
//   next-PC and registers the Execute/Writeback/MemAccess control words.
//   Ports:
//     clock, reset   single clock, synchronous active-high reset
//     enable_decode  capture strobe from Fetch
//     dout, npc_in   instruction word and its PC+1
//     psr            carried on the bus, not used here
//     IR, npc_out    registered instruction / next PC
//     E_Control      {alu_control, pcselect1, pcselect2, op2select}
//     W_Control      0=ALU, 1=memory, 2=PC (LEA)
//     Mem_Control    1 = indirect access (LDI/STI)
//     illegal_op     unsupported-opcode flag
//   Handshake: enable_decode is a one-sided strobe with no ready/back-pressure;
//   on any edge where it is high (and reset is low) all outputs load together,
//   otherwise every output holds. dout is ignored while enable_decode is low.
//   Build option: LC3_DECODE_ILLEGAL_DETECT_EN registers illegal_op; without it
//   illegal_op is constant 0.
module lc3_decode_stage
  import lc3_decode_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_decode,
  input  logic [INSTR_W-1:0] dout,
  input  logic [PC_W-1:0]    npc_in,
  input  logic [3:0]         psr,
  output logic [INSTR_W-1:0] IR,
  output logic [PC_W-1:0]    npc_out,
  output logic [5:0]         E_Control,
  output logic [1:0]         W_Control,
  output logic               Mem_Control,
  output logic               illegal_op
);

  e_ctrl_t    e_next;
  logic [1:0] w_next;
  logic       mem_next;
  logic       illegal_next;

  lc3_decode_ctrl_lut u_lut (
    .instr       (dout[15:0]),
    .e_control   (e_next),
    .w_control   (w_next),
    .mem_control (mem_next),
    .illegal     (illegal_next)
  );

  logic unused_psr;
  assign unused_psr = ^psr;

  always_ff @(posedge clock) begin
    if (reset) begin
      IR          <= '0;
      npc_out     <= '0;
      E_Control   <= '0;
      W_Control   <= '0;
      Mem_Control <= 1'b0;
    end else if (enable_decode) begin
      IR          <= dout;
      npc_out     <= npc_in;
      E_Control   <= e_next;
      W_Control   <= w_next;
      Mem_Control <= mem_next;
    end
  end

`ifdef LC3_DECODE_ILLEGAL_DETECT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_op <= 1'b0;
    end else if (enable_decode) begin
      illegal_op <= illegal_next;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal_next;
  assign illegal_op     = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// tb_lc3_decode_stage
//   Self-checking bench for lc3_decode_stage. Expected output words
//   {IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op} are pushed
//   to exp_q as stimulus is driven and popped after the capturing edge.
module tb_lc3_decode_stage;

  localparam int W = 42;

`ifdef LC3_DECODE_ILLEGAL_DETECT_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [3:0]  psr;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        illegal_op;

  always #5 clock = ~clock;

  lc3_decode_stage dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .psr           (psr),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .illegal_op    (illegal_op)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] pack(logic [15:0] ir, logic [15:0] npc, logic [5:0] e,
                                        logic [1:0] w, logic m, logic ill);
    return {ir, npc, e, w, m, ill};
  endfunction

  function automatic logic [W-1:0] actual();
    return {IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op};
  endfunction

  // Reference decode used for the randomized stream.
  function automatic logic [W-1:0] model(logic [15:0] d, logic [15:0] n);
    logic [5:0] e;
    logic [1:0] w;
    logic       m;
    logic       ill;
    e = 6'h00; w = 2'd0; m = 1'b0; ill = 1'b0;
    case (d[15:12])
      4'h1: e = {5'b00000, ~d[5]};
      4'h5: e = {5'b01000, ~d[5]};
      4'h9: e = 6'h20;
      4'h0, 4'h3: e = 6'h06;
      4'h2: begin e = 6'h06; w = 2'd1; end
      4'hA: begin e = 6'h06; w = 2'd1; m = 1'b1; end
      4'hB: begin e = 6'h06; m = 1'b1; end
      4'hE: begin e = 6'h06; w = 2'd2; end
      4'h6: begin e = 6'h08; w = 2'd1; end
      4'h7: e = 6'h08;
      4'hC: e = 6'h0C;
      default: ill = ILL_EN;
    endcase
    return pack(d, n, e, w, m, ill);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic en, input logic [15:0] d,
                       input logic [15:0] n);
    @(negedge clock);
    reset         = rst;
    enable_decode = en;
    dout          = d;
    npc_in        = n;
    psr           = 4'($urandom_range(0, 15));
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      drive(1'b1, 1'b1, 16'h12A3, 16'h3001);
      e = exp_q.pop_front();
      n_cmp++;
      if (actual() !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h expected %h", i, actual(), e);
      end
    end
  endtask

  task automatic test_add();
    logic [W-1:0] e;
    exp_q.push_back(pack(16'h12A3, 16'h3001, 6'h00, 2'd0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 16'h12A3, 16'h3001);
    e = exp_q.pop_front();
    n_cmp++;
    if (actual() !== e) begin
      n_err++;
      $display("FAIL add_imm: got %h expected %h", actual(), e);
    end
    exp_q.push_back(pack(16'h1283, 16'h3002, 6'h01, 2'd0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 16'h1283, 16'h3002);
    e = exp_q.pop_front();
    n_cmp++;
    if (actual() !== e) begin
      n_err++;
      $display("FAIL add_reg: got %h expected %h", actual(), e);
    end
  endtask

  task automatic test_stream();
    logic [15:0] ins [4] = '{16'h6285, 16'hA405, 16'hE003, 16'hC1C0};
    logic [5:0]  ev  [4] = '{6'h08, 6'h06, 6'h06, 6'h0C};
    logic [1:0]  wv  [4] = '{2'd1, 2'd1, 2'd2, 2'd0};
    logic        mv  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pack(ins[i], 16'h3010 + 16'(i), ev[i], wv[i], mv[i], 1'b0));
      drive(1'b0, 1'b1, ins[i], 16'h3010 + 16'(i));
      e = exp_q.pop_front();
      n_cmp++;
      if (actual() !== e) begin
        n_err++;
        $display("FAIL stream[%0d]: got %h expected %h", i, actual(), e);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    // AND R0,R1,R2 is register mode (dout[5]=0), so op2select=1.
    e = pack(16'h5042, 16'h4000, 6'h11, 2'd0, 1'b0, 1'b0);
    exp_q.push_back(e);
    drive(1'b0, 1'b1, 16'h5042, 16'h4000);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        exp_q.push_back(e);
        drive(1'b0, 1'b0, 16'hFFFF, 16'hBEEF);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (actual() !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got %h expected %h", i, actual(), e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] e;
    exp_q.push_back(pack(16'hF025, 16'h5000, 6'h00, 2'd0, 1'b0, ILL_EN));
    drive(1'b0, 1'b1, 16'hF025, 16'h5000);
    e = exp_q.pop_front();
    n_cmp++;
    if (actual() !== e) begin
      n_err++;
      $display("FAIL trap: got %h expected %h", actual(), e);
    end
    // illegal flag holds on stall
    exp_q.push_back(e);
    drive(1'b0, 1'b0, 16'h903F, 16'h5555);
    e = exp_q.pop_front();
    n_cmp++;
    if (actual() !== e) begin
      n_err++;
      $display("FAIL trap_hold: got %h expected %h", actual(), e);
    end
    exp_q.push_back(pack(16'h903F, 16'h5001, 6'h20, 2'd0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 16'h903F, 16'h5001);
    e = exp_q.pop_front();
    n_cmp++;
    if (actual() !== e) begin
      n_err++;
      $display("FAIL not_after_trap: got %h expected %h", actual(), e);
    end
  endtask

  task automatic test_reset_collision();
    logic [W-1:0] e;
    exp_q.push_back('0);
    drive(1'b1, 1'b1, 16'hA405, 16'h6000);
    e = exp_q.pop_front();
    n_cmp++;
    if (actual() !== e) begin
      n_err++;
      $display("FAIL reset_wins: got %h expected %h", actual(), e);
    end
    exp_q.push_back(pack(16'hA405, 16'h6001, 6'h06, 2'd1, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 16'hA405, 16'h6001);
    e = exp_q.pop_front();
    n_cmp++;
    if (actual() !== e) begin
      n_err++;
      $display("FAIL after_reset: got %h expected %h", actual(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] cur;
    logic [W-1:0] e;
    logic [15:0]  d;
    logic [15:0]  n;
    logic         en;
    logic         rst;
    cur = pack(16'hA405, 16'h6001, 6'h06, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      d   = 16'($urandom_range(0, 16'hFFFF));
      n   = 16'($urandom_range(0, 16'hFFFF));
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 15) == 0);
      if (rst)     cur = '0;
      else if (en) cur = model(d, n);
      exp_q.push_back(cur);
      drive(rst, en, d, n);
      e = exp_q.pop_front();
      n_cmp++;
      if (actual() !== e) begin
        n_err++;
        $display("FAIL b2b[%0d]: d=%h en=%0b rst=%0b got %h expected %h",
                 i, d, en, rst, actual(), e);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1; enable_decode = 1'b0; dout = '0; npc_in = '0; psr = '0;
    test_reset();
    test_add();
    test_stream();
    test_stall();
    test_illegal();
    test_reset_collision();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
